// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR3 command scheduler: request command codes,
// FSM states, command-pin encodings, error codes and default timings.
package ddr_sched_pkg;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } command_e;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_REFRESH = 2'd2
   } sched_state_e;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] PIN_DES = 4'b1111;
   localparam logic [3:0] PIN_NOP = 4'b0111;
   localparam logic [3:0] PIN_ACT = 4'b0011;
   localparam logic [3:0] PIN_RD  = 4'b0101;
   localparam logic [3:0] PIN_WR  = 4'b0100;
   localparam logic [3:0] PIN_PRE = 4'b0010;
   localparam logic [3:0] PIN_REF = 4'b0001;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_RW_CLOSED = 2'd1;
   localparam logic [1:0] ERR_ACT_OPEN  = 2'd2;
   localparam logic [1:0] ERR_REF_OPEN  = 2'd3;

   localparam int DEF_T_RCD         = 4;
   localparam int DEF_T_RP          = 4;
   localparam int DEF_T_RFC         = 20;
   localparam int DEF_T_CCD         = 4;
   localparam int DEF_INIT_CYCLES   = 16;
   localparam int DEF_MEM_BA_WIDTH  = 3;
   localparam int DEF_MEM_ROW_WIDTH = 14;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/ddr_bank_timer.sv
// Per-bank state: open flag plus a saturating down-counter that holds off
// further commands to the bank after ACT (tRCD) or PRE (tRP).
module ddr_bank_timer #(
   parameter int CNT_W = 3,
   parameter int T_RCD = 4,
   parameter int T_RP  = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic act_i,
   input  logic pre_i,
   output logic open_o,
   output logic busy_o
);

   logic             open_q;
   logic [CNT_W-1:0] cnt_q;

   // Reload on issue wins over the per-cycle decrement.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         open_q <= 1'b0;
         cnt_q  <= '0;
      end else if (act_i) begin
         open_q <= 1'b1;
         cnt_q  <= CNT_W'(T_RCD - 1);
      end else if (pre_i) begin
         open_q <= 1'b0;
         cnt_q  <= CNT_W'(T_RP - 1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign open_o = open_q;
   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR3 command scheduler: accepts one request per cycle through a
// valid/ready port, enforces tRCD/tRP/tCCD/tRFC and the power-up hold,
// and drives the command pins one cycle after transfer.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds cmd/ba/addr stable until then.
// Optional ODT control is compiled in with the DDR_ODT_CTRL_EN macro.
module ddr_cmd_scheduler
   import ddr_sched_pkg::*;
#(
   parameter int T_RCD         = DEF_T_RCD,
   parameter int T_RP          = DEF_T_RP,
   parameter int T_RFC         = DEF_T_RFC,
   parameter int T_CCD         = DEF_T_CCD,
   parameter int INIT_CYCLES   = DEF_INIT_CYCLES,
   parameter int MEM_BA_WIDTH  = DEF_MEM_BA_WIDTH,
   parameter int MEM_ROW_WIDTH = DEF_MEM_ROW_WIDTH
) (
   input  logic                     ck_t,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               req_cmd,
   input  logic [MEM_BA_WIDTH-1:0]  req_ba,
   input  logic [MEM_ROW_WIDTH-1:0] req_addr,
   output logic                     cke,
   output logic                     cs_n,
   output logic                     ras_n,
   output logic                     cas_n,
   output logic                     we_n,
   output logic [MEM_BA_WIDTH-1:0]  ba,
   output logic [MEM_ROW_WIDTH-1:0] a,
   output logic                     odt,
   output logic                     err_valid,
   output logic [1:0]               err_code,
   output logic [1:0]               dbg_state_o
);

   localparam int NUM_BANKS  = 1 << MEM_BA_WIDTH;
   localparam int BANK_CNT_W = $clog2(max_int(T_RCD, T_RP)) + 1;
   localparam int CNT_W      = $clog2(max_int(INIT_CYCLES, T_RFC)) + 1;
   localparam int CCD_W      = $clog2(T_CCD) + 1;

   sched_state_e             state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CCD_W-1:0]         ccd_q, ccd_d;
   logic [3:0]               pins_q, pins_d;
   logic [MEM_ROW_WIDTH-1:0] a_q, a_d;
   logic [MEM_BA_WIDTH-1:0]  ba_q, ba_d;
   logic                     err_valid_q, err_valid_d;
   logic [1:0]               err_code_q, err_code_d;

   logic [NUM_BANKS-1:0]     bank_open, bank_busy;
   logic [NUM_BANKS-1:0]     act_vec, pre_vec;
   command_e                 cmd;
   logic                     fire;
   logic                     issue_act, issue_pre, issue_rd, issue_wr, issue_ref;

   assign cmd = command_e'(req_cmd);

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      ddr_bank_timer #(
         .CNT_W (BANK_CNT_W),
         .T_RCD (T_RCD),
         .T_RP  (T_RP)
      ) u_timer (
         .clk_i   (ck_t),
         .reset_i (reset),
         .act_i   (act_vec[g]),
         .pre_i   (pre_vec[g]),
         .open_o  (bank_open[g]),
         .busy_o  (bank_busy[g])
      );
   end

   // Ready depends on the addressed bank's timer, the tCCD window and, for
   // REF, on every bank having finished its tRCD/tRP wait.
   always_comb begin
      req_ready = 1'b0;
      if (!reset && state_q == ST_IDLE) begin
         case (cmd)
            CMD_ACT, CMD_PRE: req_ready = !bank_busy[req_ba];
            CMD_RD, CMD_WR:   req_ready = !bank_busy[req_ba] && (ccd_q == '0);
            CMD_REF:          req_ready = !(|bank_busy);
            default:          req_ready = 1'b1;
         endcase
      end
   end

   // Classify a transferred request as issued or illegal.
   always_comb begin
      fire        = req_valid && req_ready;
      issue_act   = 1'b0;
      issue_pre   = 1'b0;
      issue_rd    = 1'b0;
      issue_wr    = 1'b0;
      issue_ref   = 1'b0;
      err_valid_d = 1'b0;
      err_code_d  = ERR_NONE;
      act_vec     = '0;
      pre_vec     = '0;
      if (fire) begin
         case (cmd)
            CMD_ACT: begin
               if (bank_open[req_ba]) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_ACT_OPEN;
               end else begin
                  issue_act       = 1'b1;
                  act_vec[req_ba] = 1'b1;
               end
            end
            CMD_RD, CMD_WR: begin
               if (!bank_open[req_ba]) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_RW_CLOSED;
               end else if (cmd == CMD_RD) begin
                  issue_rd = 1'b1;
               end else begin
                  issue_wr = 1'b1;
               end
            end
            CMD_PRE: begin
               issue_pre       = 1'b1;
               pre_vec[req_ba] = 1'b1;
            end
            CMD_REF: begin
               if (|bank_open) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_REF_OPEN;
               end else begin
                  issue_ref = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM next state: power-up hold, idle, refresh blackout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (issue_ref) begin
               state_d = ST_REFRESH;
               cnt_d   = '0;
            end
         end
         ST_REFRESH: begin
            if (cnt_q == CNT_W'(T_RFC - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Next pin values; idle cycles drive NOP (deselect during INIT) and keep a/ba.
   always_comb begin
      pins_d = (state_d == ST_INIT) ? PIN_DES : PIN_NOP;
      a_d    = a_q;
      ba_d   = ba_q;
      ccd_d  = (ccd_q != '0) ? ccd_q - 1'b1 : ccd_q;
      if (issue_act) begin
         pins_d = PIN_ACT;
         a_d    = req_addr;
         ba_d   = req_ba;
      end else if (issue_rd || issue_wr) begin
         pins_d = issue_rd ? PIN_RD : PIN_WR;
         a_d    = req_addr;
         ba_d   = req_ba;
         ccd_d  = CCD_W'(T_CCD - 1);
      end else if (issue_pre) begin
         pins_d = PIN_PRE;
         a_d    = req_addr;
         a_d[10] = 1'b0;
         ba_d   = req_ba;
      end else if (issue_ref) begin
         pins_d = PIN_REF;
      end
   end

   // State and output registers.
   always_ff @(posedge ck_t) begin
      if (reset) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         ccd_q       <= '0;
         pins_q      <= PIN_DES;
         a_q         <= '0;
         ba_q        <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ccd_q       <= ccd_d;
         pins_q      <= pins_d;
         a_q         <= a_d;
         ba_q        <= ba_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

`ifdef DDR_ODT_CTRL_EN
   // WR issue cycle plus four more; a later WR reloads the window.
   localparam logic [2:0] ODT_LOAD = 3'd5;
   logic [2:0] odt_cnt_q, odt_cnt_d;

   // ODT window counter next value.
   always_comb begin
      odt_cnt_d = odt_cnt_q;
      if (issue_wr) begin
         odt_cnt_d = ODT_LOAD;
      end else if (odt_cnt_q != 3'd0) begin
         odt_cnt_d = odt_cnt_q - 3'd1;
      end
   end

   // ODT window counter register.
   always_ff @(posedge ck_t) begin
      if (reset) begin
         odt_cnt_q <= 3'd0;
      end else begin
         odt_cnt_q <= odt_cnt_d;
      end
   end

   assign odt = (odt_cnt_q != 3'd0);
`else
   assign odt = 1'b0;
`endif

   assign cke         = (state_q != ST_INIT);
   assign {cs_n, ras_n, cas_n, we_n} = pins_q;
   assign a           = a_q;
   assign ba          = ba_q;
   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: power-up hold, ACT->RD spacing,
// tCCD spacing, illegal requests, refresh blackout, reset during refresh
// and the optional ODT window (DDR_ODT_CTRL_EN).
module tb_ddr_cmd_scheduler;
   import ddr_sched_pkg::*;

   // expected pin codes {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] E_DES = 4'b1111;
   localparam logic [3:0] E_NOP = 4'b0111;
   localparam logic [3:0] E_ACT = 4'b0011;
   localparam logic [3:0] E_RD  = 4'b0101;
   localparam logic [3:0] E_WR  = 4'b0100;
   localparam logic [3:0] E_PRE = 4'b0010;
   localparam logic [3:0] E_REF = 4'b0001;

   logic        ck_t = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_cmd = 3'd0;
   logic [2:0]  req_ba = 3'd0;
   logic [13:0] req_addr = 14'd0;
   logic        req_ready, cke, cs_n, ras_n, cas_n, we_n, odt, err_valid;
   logic [2:0]  ba;
   logic [13:0] a;
   logic [1:0]  err_code, dbg_state;
   logic [3:0]  pins;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [13:0] exp_q[$];
   logic [3:0]  mon_pins_q[$];
   logic [13:0] mon_a_q[$];
   int          mon_cyc_q[$];

   assign pins = {cs_n, ras_n, cas_n, we_n};

   ddr_cmd_scheduler dut (
      .ck_t        (ck_t),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_cmd     (req_cmd),
      .req_ba      (req_ba),
      .req_addr    (req_addr),
      .cke         (cke),
      .cs_n        (cs_n),
      .ras_n       (ras_n),
      .cas_n       (cas_n),
      .we_n        (we_n),
      .ba          (ba),
      .a           (a),
      .odt         (odt),
      .err_valid   (err_valid),
      .err_code    (err_code),
      .dbg_state_o (dbg_state)
   );

   // clock and cycle counter
   always #5 ck_t = ~ck_t;

   always @(posedge ck_t) cyc <= cyc + 1;

   // monitor: log every real command seen on the pins
   always @(negedge ck_t) begin
      if (!reset && pins !== E_NOP && pins !== E_DES) begin
         mon_pins_q.push_back(pins);
         mon_a_q.push_back(a);
         mon_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge, wait (bounded) for ready, let it
   // transfer, and return at the negedge after transfer with valid dropped.
   task automatic send(input logic [2:0] c, input logic [2:0] b,
                       input logic [13:0] ad, output int waited);
      req_valid = 1'b1;
      req_cmd   = c;
      req_ba    = b;
      req_addr  = ad;
      waited    = 0;
      #1;
      while (!req_ready && waited < 200) begin
         @(negedge ck_t);
         #1;
         waited++;
      end
      chk("ready_seen", req_ready, 1'b1);
      @(posedge ck_t);
      @(negedge ck_t);
      req_valid = 1'b0;
      req_cmd   = CMD_NOP;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cke"}, cke, 1'b0);
      chk({tag, "_pins"}, pins, E_DES);
      chk({tag, "_a"}, a, 14'h0);
      chk({tag, "_ba"}, ba, 3'd0);
      chk({tag, "_odt"}, odt, 1'b0);
      chk({tag, "_errv"}, err_valid, 1'b0);
      chk({tag, "_errc"}, err_code, 2'd0);
      chk({tag, "_ready"}, req_ready, 1'b0);
   endtask

   // Called at the negedge after the last reset edge; releases reset and
   // measures how many samples cke stays low.
   task automatic release_and_init(input string tag);
      int n;
      reset = 1'b0;
      n = 0;
      while (cke === 1'b0 && n < 100) begin
         n++;
         @(negedge ck_t);
      end
      chk({tag, "_init_len"}, n, 16);
      #1;
      chk({tag, "_cke_up"}, cke, 1'b1);
      chk({tag, "_ready_up"}, req_ready, 1'b1);
      chk({tag, "_nop_pins"}, pins, E_NOP);
      chk({tag, "_state_idle"}, dbg_state, 2'd1);
   endtask

   initial begin
      int w;
      int n;
      logic [13:0] e;

      // reset values
      repeat (3) @(negedge ck_t);
      chk_reset_outputs("rst");
      release_and_init("pwr");

      // NOP request is accepted at once and changes nothing
      @(negedge ck_t);
      send(CMD_NOP, 3'd0, 14'h0, w);
      chk("nop_wait", w, 0);
      chk("nop_pins", pins, E_NOP);
      chk("nop_err", err_valid, 1'b0);

      // ACT then held RD to the same bank: tRCD spacing
      send(CMD_ACT, 3'd2, 14'h1A5, w);
      chk("act_pins", pins, E_ACT);
      chk("act_a", a, 14'h1A5);
      chk("act_ba", ba, 3'd2);
      send(CMD_RD, 3'd2, 14'h010, w);
      chk("rcd_gap", w + 1, 4);
      chk("rd_pins", pins, E_RD);
      chk("rd_a", a, 14'h010);
      chk("rd_ba", ba, 3'd2);
      @(negedge ck_t);
      chk("rd_one_cycle", pins, E_NOP);
      chk("nop_hold_a", a, 14'h010);
      chk("nop_hold_ba", ba, 3'd2);

      // back-to-back RDs: tCCD spacing with NOPs between
      mon_pins_q.delete();
      mon_a_q.delete();
      mon_cyc_q.delete();
      exp_q.push_back(14'h020);
      exp_q.push_back(14'h030);
      exp_q.push_back(14'h040);
      send(CMD_RD, 3'd2, 14'h020, w);
      send(CMD_RD, 3'd2, 14'h030, w);
      send(CMD_RD, 3'd2, 14'h040, w);
      @(negedge ck_t);
      chk("ccd_cmd_count", mon_cyc_q.size(), 3);
      if (mon_cyc_q.size() == 3) begin
         chk("ccd_gap_1", mon_cyc_q[1] - mon_cyc_q[0], 4);
         chk("ccd_gap_2", mon_cyc_q[2] - mon_cyc_q[1], 4);
      end
      while (exp_q.size() > 0 && mon_a_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ccd_rd_pins", mon_pins_q.pop_front(), E_RD);
         chk("ccd_rd_a", mon_a_q.pop_front(), e);
      end

      // RD to closed bank 5: NOP on pins, error pulse, a/ba held
      send(CMD_RD, 3'd5, 14'h055, w);
      chk("rdc_pins", pins, E_NOP);
      chk("rdc_errv", err_valid, 1'b1);
      chk("rdc_errc", err_code, 2'd1);
      chk("rdc_a_hold", a, 14'h040);
      chk("rdc_ba_hold", ba, 3'd2);
      @(negedge ck_t);
      chk("rdc_err_pulse", err_valid, 1'b0);

      // next request accepted at once: PRE with a[10] forced low
      send(CMD_PRE, 3'd2, 14'h0400, w);
      chk("pre_wait", w, 0);
      chk("pre_pins", pins, E_PRE);
      chk("pre_a10", a, 14'h0000);
      chk("pre_ba", ba, 3'd2);

      // REF with all banks closed: 20-cycle blackout
      send(CMD_REF, 3'd0, 14'h0, w);
      chk("ref_pins", pins, E_REF);
      chk("ref_state", dbg_state, 2'd2);
      #1;
      n = 0;
      while (req_ready === 1'b0 && n < 100) begin
         n++;
         @(negedge ck_t);
         #1;
      end
      chk("rfc_len", n, 20);

      // REF with bank 0 open is rejected
      send(CMD_ACT, 3'd0, 14'h0AB, w);
      chk("act0_pins", pins, E_ACT);
      send(CMD_REF, 3'd0, 14'h0, w);
      chk("refo_pins", pins, E_NOP);
      chk("refo_errv", err_valid, 1'b1);
      chk("refo_errc", err_code, 2'd3);
      chk("refo_state", dbg_state, 2'd1);

      // ACT to an open bank is rejected
      send(CMD_ACT, 3'd0, 14'h0CD, w);
      chk("acto_pins", pins, E_NOP);
      chk("acto_errc", err_code, 2'd2);
      chk("acto_a_hold", a, 14'h0AB);

      // WR to open bank 0 and the ODT window
      send(CMD_WR, 3'd0, 14'h033, w);
      chk("wr_pins", pins, E_WR);
      chk("wr_a", a, 14'h033);
      chk("wr_ba", ba, 3'd0);
`ifdef DDR_ODT_CTRL_EN
      n = 0;
      while (odt === 1'b1 && n < 20) begin
         n++;
         @(negedge ck_t);
      end
      chk("odt_len", n, 5);
`else
      n = 0;
      repeat (6) begin
         if (odt !== 1'b0) n++;
         @(negedge ck_t);
      end
      chk("odt_tied_low", n, 0);
`endif

      // reset three cycles into REFRESH
      send(CMD_PRE, 3'd0, 14'h0, w);
      send(CMD_REF, 3'd0, 14'h0, w);
      chk("ref2_pins", pins, E_REF);
      repeat (2) @(negedge ck_t);
      chk("ref2_state", dbg_state, 2'd2);
      reset = 1'b1;
      @(negedge ck_t);
      chk_reset_outputs("mid_ref_rst");
      chk("mid_ref_state", dbg_state, 2'd0);
      release_and_init("rerun");

      // reset closed every bank and cleared the counters
      @(negedge ck_t);
      send(CMD_RD, 3'd0, 14'h001, w);
      chk("post_rst_wait", w, 0);
      chk("post_rst_pins", pins, E_NOP);
      chk("post_rst_errc", err_code, 2'd1);

      repeat (2) @(negedge ck_t);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
